// File: rtl/dm_dmi_responder_pkg.sv
// Shared definitions for the DMI responder: bus widths, DMI op/response
// encodings and the response packing helper.
package dm_dmi_responder_pkg;

    localparam int DBUS_ADDR_WIDTH = 7;
    localparam int DBUS_DATA_WIDTH = 32;
    localparam int DBUS_OP_WIDTH   = 2;
    localparam int DBUS_M_WIDTH    = DBUS_ADDR_WIDTH + DBUS_DATA_WIDTH + DBUS_OP_WIDTH;
    localparam int DBUS_S_WIDTH    = DBUS_DATA_WIDTH + 2;

    // Request op encodings (op 3 is reserved and answered with a failure)
    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    // Response op encodings
    localparam logic [1:0] DMI_RESP_OK   = 2'd0;
    localparam logic [1:0] DMI_RESP_FAIL = 2'd2;

    // Response word layout: {data, op} with op in the LSBs
    function automatic logic [DBUS_S_WIDTH-1:0] pack_resp(
        input logic [DBUS_DATA_WIDTH-1:0] data,
        input logic [1:0]                 op
    );
        return {data, op};
    endfunction

endpackage

// File: rtl/dm_dmi_responder_if.sv
// Signal bundle between the DTM-side FIFOs, the DMI responder and the DM
// core register port. The responder uses the slave view; the environment
// driving requests and serving register accesses uses the master view.
interface dm_dmi_responder_if;
    import dm_dmi_responder_pkg::*;

    // Request stream from the TCK->sys_clk FIFO
    logic                       dtm_req_valid;
    logic                       dtm_req_ready;
    logic [DBUS_M_WIDTH-1:0]    dtm_req_bits;

    // Response stream into the sys_clk->TCK FIFO
    logic                       dm_resp_valid;
    logic                       dm_resp_ready;
    logic [DBUS_S_WIDTH-1:0]    dm_resp_bits;

    // Register port into the DM core
    logic                       reg_req;
    logic                       reg_we;
    logic [DBUS_ADDR_WIDTH-1:0] reg_addr;
    logic [DBUS_DATA_WIDTH-1:0] reg_wdata;
    logic [DBUS_DATA_WIDTH-1:0] reg_rdata;
    logic                       reg_ack;
    logic                       reg_err;

    modport slave (
        input  dtm_req_valid, dtm_req_bits, dm_resp_ready,
        input  reg_rdata, reg_ack, reg_err,
        output dtm_req_ready, dm_resp_valid, dm_resp_bits,
        output reg_req, reg_we, reg_addr, reg_wdata
    );

    modport master (
        output dtm_req_valid, dtm_req_bits, dm_resp_ready,
        output reg_rdata, reg_ack, reg_err,
        input  dtm_req_ready, dm_resp_valid, dm_resp_bits,
        input  reg_req, reg_we, reg_addr, reg_wdata
    );

endinterface

// File: rtl/dm_dmi_responder.sv
// DMI responder, debug-module side of the DTM<->DM link (sys_clk domain).
// Runs each DMI request as a single register-port transaction and returns
// exactly one {data, op} response per accepted request.
// Optional macro DM_DMI_TIMEOUT_EN: abandons a register access that gets no
// reg_ack within TIMEOUT_CYCLES cycles and reports it as a failure.
module dm_dmi_responder
    import dm_dmi_responder_pkg::*;
#(
`ifdef DM_DMI_TIMEOUT_EN
    parameter int unsigned                 TIMEOUT_CYCLES = 255,
`endif
    parameter logic [DBUS_ADDR_WIDTH-1:0]  MAX_ADDR       = 7'h17
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    dm_dmi_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                     state_q;
    logic                       resp_valid_q;
    logic [DBUS_S_WIDTH-1:0]    resp_bits_q;
    logic                       reg_req_q;
    logic                       reg_we_q;
    logic [DBUS_ADDR_WIDTH-1:0] reg_addr_q;
    logic [DBUS_DATA_WIDTH-1:0] reg_wdata_q;
    logic [DBUS_S_WIDTH-1:0]    acc_resp_d;

    logic [DBUS_ADDR_WIDTH-1:0] req_addr;
    logic [DBUS_DATA_WIDTH-1:0] req_data;
    logic [1:0]                 req_op;

`ifdef DM_DMI_TIMEOUT_EN
    // Width holds TIMEOUT_CYCLES-1 even for tiny limits
    localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]             tmo_cnt_q;
`endif

    assign req_op   = bus.dtm_req_bits[DBUS_OP_WIDTH-1:0];
    assign req_data = bus.dtm_req_bits[DBUS_OP_WIDTH +: DBUS_DATA_WIDTH];
    assign req_addr = bus.dtm_req_bits[DBUS_OP_WIDTH + DBUS_DATA_WIDTH +: DBUS_ADDR_WIDTH];

    // Ready is the only combinational output: it must be low during reset
    assign bus.dtm_req_ready = (state_q == ST_IDLE) && !sys_rst;

    assign bus.dm_resp_valid = resp_valid_q;
    assign bus.dm_resp_bits  = resp_bits_q;
    assign bus.reg_req       = reg_req_q;
    assign bus.reg_we        = reg_we_q;
    assign bus.reg_addr      = reg_addr_q;
    assign bus.reg_wdata     = reg_wdata_q;

    // Response produced by a completed access; writes return zero data
    always_comb begin
        acc_resp_d = pack_resp(reg_we_q ? {DBUS_DATA_WIDTH{1'b0}} : bus.reg_rdata,
                               bus.reg_err ? DMI_RESP_FAIL : DMI_RESP_OK);
    end

    // Transaction FSM with registered response and register-port outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
            reg_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
`ifdef DM_DMI_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.dtm_req_valid) begin
                        if (req_op == DMI_OP_NOP) begin
                            resp_bits_q  <= pack_resp('0, DMI_RESP_OK);
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if ((req_op == DMI_OP_READ || req_op == DMI_OP_WRITE) &&
                                     req_addr <= MAX_ADDR) begin
                            reg_req_q   <= 1'b1;
                            reg_we_q    <= (req_op == DMI_OP_WRITE);
                            reg_addr_q  <= req_addr;
                            reg_wdata_q <= req_data;
`ifdef DM_DMI_TIMEOUT_EN
                            tmo_cnt_q   <= '0;
`endif
                            state_q     <= ST_ACCESS;
                        end else begin
                            // Reserved op or out-of-range address: no register access
                            resp_bits_q  <= pack_resp('0, DMI_RESP_FAIL);
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (bus.reg_ack) begin
                        reg_req_q    <= 1'b0;
                        resp_bits_q  <= acc_resp_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
`ifdef DM_DMI_TIMEOUT_EN
                    end else if (tmo_cnt_q == CNT_LAST) begin
                        reg_req_q    <= 1'b0;
                        resp_bits_q  <= pack_resp('0, DMI_RESP_FAIL);
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        tmo_cnt_q    <= tmo_cnt_q + 1'b1;
`endif
                    end
                end

                ST_RESP: begin
                    if (bus.dm_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
